apb_dpmem_param: RTL
====================

// Module: apb_dpmem_param
// PURPOSE
//  Parametrised APB slave memory, next generation of the dual-port APB memory.
//  Port A is an APB3/4 slave: programmable read/write wait states, byte strobes,
//  and a programmable read-only window. Unmapped accesses return PSLVERR.
//  Port B is a native single-cycle RAM port for a local master such as DMA or a core.
//  Both ports share one byte-writable array; collisions are resolved in this block.
// PARAMETERS
//  ADDR_WIDTH  10            word address width; DEPTH = MEM_DEPTH words
//  DATA_WIDTH  32            data width; multiple of 8; STRB_WIDTH = DATA_WIDTH/8
//  MEM_DEPTH   1<<ADDR_WIDTH implemented words; PADDR >= MEM_DEPTH is unmapped
//  READ_WAIT   1             APB read wait states (0 = zero-wait)
//  WRITE_WAIT  3             APB write wait states (0 = zero-wait)
//  RO_BASE     'h111         first read-only word address (APB side only)
//  RO_LIMIT    'h111         last read-only word address, inclusive
// PORTS
//  PCLK     in   1           single clock for both ports
//  PRESET   in   1           asynchronous, active-high reset
//  PSEL     in   1           APB select
//  PENABLE  in   1           APB enable
//  PWRITE   in   1           1 = write
//  PADDR    in   ADDR_WIDTH  APB word address
//  PWDATA   in   DATA_WIDTH  APB write data
//  PSTRB    in   STRB_WIDTH  APB byte strobes
//  PRDATA   out  DATA_WIDTH  APB read data
//  PREADY   out  1           APB ready
//  PSLVERR  out  1           APB error
//  B_EN     in   1           port B access enable
//  B_WE     in   1           port B write enable (valid with B_EN)
//  B_ADDR   in   ADDR_WIDTH  port B word address
//  B_WDATA  in   DATA_WIDTH  port B write data
//  B_BE     in   STRB_WIDTH  port B byte enables
//  B_RDATA  out  DATA_WIDTH  port B read data; registered, 1-cycle latency
// BEHAVIOUR
//  Reset
//   - All outputs are 0; FSM = IDLE; wait counter = 0; B_RDATA register = 0.
//   - Memory contents are not cleared.
//   - Reset asserted mid-transfer aborts it: no write commits, and PREADY/PSLVERR drop at once.
//  APB FSM (IDLE, SETUP, ACCESS)
//   - IDLE -> SETUP when PSEL & !PENABLE.
//   - SETUP -> ACCESS when PSEL & PENABLE. The wait counter loads READ_WAIT or WRITE_WAIT,
//     chosen by PWRITE.
//   - In ACCESS the counter decrements each cycle while it is nonzero.
//   - PREADY = (cnt == 0), combinational, so a transfer spans SETUP + 1 + WAIT cycles.
//   - ACCESS & PREADY: next state is SETUP if PSEL & !PENABLE, otherwise IDLE.
//   - PSEL low during ACCESS aborts: no write, go to IDLE.
//  Errors
//   - An access is in error if PADDR >= MEM_DEPTH, or if it is a write with
//     RO_BASE <= PADDR <= RO_LIMIT.
//   - An error access gets PREADY = PSLVERR = 1 in the first ACCESS cycle; wait states are skipped.
//   - An error access performs no write, and PRDATA = 0.
//  Read and write data
//   - PRDATA = MEM[PADDR] only while ACCESS & PREADY & !PWRITE & !error; otherwise 0.
//   - An APB write commits on the PCLK edge that ends the ACCESS & PREADY cycle.
//   - Only bytes with PSTRB[i] = 1 are written; PSTRB = 0 is a legal no-op that returns OKAY.
//  Port B
//   - B_EN & B_WE writes the bytes with B_BE set at the next edge.
//   - B_EN & !B_WE: B_RDATA = MEM[B_ADDR] one cycle later, and holds until the next read.
//   - Port B has no error path. Addresses >= MEM_DEPTH are ignored and read as 0.
//   - The RO window does not apply to port B.
//  Collisions (same word, same edge)
//   - APB commit and port B write to the same word: APB wins for the bytes in PSTRB,
//     port B wins for the remaining bytes in B_BE.
//   - Port B read in the same cycle as a write to that word, from either port,
//     returns the old data (read-first).
//   - An APB read sampled in the same cycle as a port B write returns the old data.
// STRUCTURE
//  - apb_pkg gains: apb_state_t (reused), data_t and strb_t derived from DATA_WIDTH,
//    and function in_ro_window().
//  - Sub-module dpmem_bytewr_ram holds the array: two ports, byte enables, read-first,
//    fixed A-over-B byte merge.
//  - Top level contains only the FSM, the counter, error decode and APB muxing.
// TESTING
//  - Reset check: after PRESET pulse, PREADY = PSLVERR = 0, PRDATA = 0, B_RDATA = 0.
//  - APB write 0xA5A5_1234 to 0x010 with PSTRB = 4'b1111, WRITE_WAIT = 3
//    -> PREADY high in the 4th ACCESS cycle; readback gives 0xA5A5_1234 after 1 wait.
//  - Write 0xFFFF_FFFF with PSTRB = 4'b0101 over 0x0 -> word reads 0x00FF_00FF.
//  - Write to 0x111 -> PSLVERR = 1 and PREADY = 1 in the first ACCESS cycle; a later read of 0x111
//    returns OKAY with unchanged data.
//  - Same-edge collision: APB writes 0x1111_1111 (PSTRB = 4'b0011) and port B writes 0x2222_2222
//    (B_BE = 4'hF) to 0x020 -> word = 0x2222_1111.
//  - Back-to-back APB reads with no IDLE, then PRESET asserted mid-ACCESS of a write
//    -> target word unchanged, FSM in IDLE.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : apb_pkg
//  Description : Shared types and helpers for the parametrised APB dual-port
//                memory: APB FSM state encoding, default-width data/strobe
//                types and the read-only window decode.
//  Contents    : apb_state_t, data_t, strb_t, in_ro_window()
//  Revision    : 2.0 - parametrised next-generation memory
// ============================================================================
package apb_pkg;

    localparam int C_ADDR_WIDTH = 10;
    localparam int C_DATA_WIDTH = 32;
    localparam int C_STRB_WIDTH = C_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    typedef logic [C_DATA_WIDTH-1:0] data_t;
    typedef logic [C_STRB_WIDTH-1:0] strb_t;

    // Inclusive window test; all operands widened to 32 bits by the caller.
    function automatic logic in_ro_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpmem_bytewr_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dpmem_bytewr_ram
//  Description : Two-port byte-writable word array.
//                Port A: write with byte strobes, combinational read.
//                Port B: write with byte enables, registered read (read-first).
//                On a same-word, same-edge double write, port A owns its
//                strobed bytes and port B keeps the rest of its enabled bytes.
//                Out-of-range addresses never write and read as zero.
//  Ports       : clk, rst          clock, async active-high reset (read reg)
//                i_a_we/addr/wdata/strb, o_a_rdata      port A
//                i_b_en/we/addr/wdata/be, o_b_rdata     port B
//  Revision    : 2.0 - parametrised next-generation memory
// ============================================================================
module dpmem_bytewr_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_a_we,
    input  logic [ADDR_WIDTH-1:0]   i_a_addr,
    input  logic [DATA_WIDTH-1:0]   i_a_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_a_strb,
    output logic [DATA_WIDTH-1:0]   o_a_rdata,
    input  logic                    i_b_en,
    input  logic                    i_b_we,
    input  logic [ADDR_WIDTH-1:0]   i_b_addr,
    input  logic [DATA_WIDTH-1:0]   i_b_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_b_be,
    output logic [DATA_WIDTH-1:0]   o_b_rdata
);

    localparam int c_strb_width = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_b_rdata;
    logic                  w_a_in_range;
    logic                  w_b_in_range;

    assign w_a_in_range = 32'(i_a_addr) < 32'(MEM_DEPTH);
    assign w_b_in_range = 32'(i_b_addr) < 32'(MEM_DEPTH);

    // Port B bytes are assigned first and port A second, so the later
    // non-blocking update gives port A ownership of its strobed bytes.
    always_ff @(posedge clk) begin
        if (i_b_en && i_b_we && w_b_in_range) begin
            for (int i = 0; i < c_strb_width; i++) begin
                if (i_b_be[i]) begin
                    r_mem[i_b_addr][i*8 +: 8] <= i_b_wdata[i*8 +: 8];
                end
            end
        end
        if (i_a_we && w_a_in_range) begin
            for (int i = 0; i < c_strb_width; i++) begin
                if (i_a_strb[i]) begin
                    r_mem[i_a_addr][i*8 +: 8] <= i_a_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Sampling the array before this edge's writes land gives read-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b_rdata <= '0;
        end else if (i_b_en && !i_b_we) begin
            r_b_rdata <= w_b_in_range ? r_mem[i_b_addr] : '0;
        end
    end

    assign o_b_rdata = r_b_rdata;
    assign o_a_rdata = w_a_in_range ? r_mem[i_a_addr] : '0;

endmodule
`default_nettype wire

// File: rtl/apb_dpmem_param.sv
`default_nettype none
// ============================================================================
//  Module      : apb_dpmem_param
//  Description : Parametrised APB slave memory with a native local port.
//                APB side: programmable read/write wait states, byte strobes,
//                read-only window, PSLVERR on unmapped or read-only writes.
//                Port B: single-cycle RAM port, registered read data.
//  Ports       : PCLK, PRESET                        clock, async reset
//                PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB  APB request
//                PRDATA/PREADY/PSLVERR               APB response
//                B_EN/B_WE/B_ADDR/B_WDATA/B_BE/B_RDATA   local port
//  Revision    : 2.0 - parametrised next-generation memory
// ============================================================================
module apb_dpmem_param
    import apb_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter int          MEM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int          READ_WAIT  = 1,
    parameter int          WRITE_WAIT = 3,
    parameter int unsigned RO_BASE    = 'h111,
    parameter int unsigned RO_LIMIT   = 'h111
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic                    B_EN,
    input  logic                    B_WE,
    input  logic [ADDR_WIDTH-1:0]   B_ADDR,
    input  logic [DATA_WIDTH-1:0]   B_WDATA,
    input  logic [DATA_WIDTH/8-1:0] B_BE,
    output logic [DATA_WIDTH-1:0]   B_RDATA
);

    localparam int c_max_wait = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int c_cnt_w    = (c_max_wait < 1) ? 1 : $clog2(c_max_wait + 1);
    localparam logic [c_cnt_w-1:0] c_read_wait  = c_cnt_w'(READ_WAIT);
    localparam logic [c_cnt_w-1:0] c_write_wait = c_cnt_w'(WRITE_WAIT);

    apb_state_t            r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  w_err;
    logic                  w_access;
    logic                  w_pready;
    logic                  w_apb_we;
    logic [DATA_WIDTH-1:0] w_a_rdata;

    // Address and direction are held stable for the whole transfer, so the
    // error decode can be combinational off the live bus.
    assign w_err = (32'(PADDR) >= 32'(MEM_DEPTH)) ||
                   (PWRITE && in_ro_window(32'(PADDR), 32'(RO_BASE), 32'(RO_LIMIT)));

    // An erroring access completes in its first ACCESS cycle regardless of
    // the loaded wait count.
    assign w_access = (r_state == ST_ACCESS);
    assign w_pready = w_access && ((r_cnt == '0) || w_err);
    assign w_apb_we = w_pready && PSEL && PWRITE && !w_err;

    assign PREADY  = w_pready;
    assign PSLVERR = w_access && w_err;
    assign PRDATA  = (w_pready && !PWRITE && !w_err) ? w_a_rdata : '0;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (!PSEL) begin
                        r_state <= ST_IDLE;
                    end else if (PENABLE) begin
                        r_state <= ST_ACCESS;
                        r_cnt   <= PWRITE ? c_write_wait : c_read_wait;
                    end
                end
                ST_ACCESS: begin
                    if (!PSEL) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_pready) begin
                        r_state <= (PSEL && !PENABLE) ? ST_SETUP : ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    dpmem_bytewr_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk       (PCLK),
        .rst       (PRESET),
        .i_a_we    (w_apb_we),
        .i_a_addr  (PADDR),
        .i_a_wdata (PWDATA),
        .i_a_strb  (PSTRB),
        .o_a_rdata (w_a_rdata),
        .i_b_en    (B_EN),
        .i_b_we    (B_WE),
        .i_b_addr  (B_ADDR),
        .i_b_wdata (B_WDATA),
        .i_b_be    (B_BE),
        .o_b_rdata (B_RDATA)
    );

endmodule
`default_nettype wire
